idli_sqi_seq_m: RTL and testbench

IDLI_SQI_SEQ_M -- requirements
Module: idli_sqi_seq_m

---
 rtl/idli_pkg.sv | 17 +
 rtl/idli_sqi_ctr_m.sv | 27 ++
 rtl/idli_sqi_seq_m.sv | 170 +++++++++++++++++
 tb/tb_idli_sqi_seq_m.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/idli_pkg.sv
// Shared definitions for the idli SQI memory path.
//   sqi_state_t : controller phase, shared by the SQI controller and the sequencer's shadow copy.
//   nibble_le   : picks nibble idx (0 = bits [3:0]) of a 16-bit word, little-endian nibble order.
package idli_pkg;

  typedef enum logic [1:0] {
    SqiInit  = 2'd0,
    SqiAddr  = 2'd1,
    SqiDummy = 2'd2,
    SqiData  = 2'd3
  } sqi_state_t;

  function automatic logic [3:0] nibble_le(input logic [15:0] word, input logic [1:0] idx);
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/idli_sqi_ctr_m.sv
// Free-running cycle-within-period counter for the SQI sequencer.
// Ports:
//   i_ctr_gck        : clock, rising edge
//   i_ctr_rst        : asynchronous active-high reset
//   o_ctr            : counter value, 0..3, wraps 3->0
//   o_ctr_last_cycle : high when o_ctr == 3
module idli_sqi_ctr_m (
  input  logic       i_ctr_gck,
  input  logic       i_ctr_rst,
  output logic [1:0] o_ctr,
  output logic       o_ctr_last_cycle
);

  logic [1:0] ctr_q;

  always_ff @(posedge i_ctr_gck or posedge i_ctr_rst) begin
    if (i_ctr_rst) begin
      ctr_q <= 2'd0;
    end else begin
      ctr_q <= ctr_q + 2'd1;
    end
  end

  assign o_ctr            = ctr_q;
  assign o_ctr_last_cycle = (ctr_q == 2'd3);

endmodule

// File: rtl/idli_sqi_seq_m.sv
// SQI sequencer: shadows the SQI controller phase, holds one pending request and feeds the
// controller the address/write nibbles it needs for each transaction.
// Optional feature: define IDLI_SQI_SEQ_WR_EN to support writes; otherwise every request is a
// read and i_seq_req_rd / i_seq_req_data are ignored.
// Ports:
//   i_seq_gck, i_seq_rst          : clock, asynchronous active-high reset
//   i_seq_req_vld/_rd/_addr/_data : request from the core (redirect), o_seq_req_rdy = slot empty
//   o_seq_ctr, o_seq_ctr_last_cycle : cycle-within-period counter
//   o_seq_redirect                : end the current DATA stream at this period boundary
//   o_seq_rd                      : direction of the active transaction
//   o_seq_wr_data, _vld           : nibble for the controller's address/data register
//   o_seq_addr                    : address of the word in the current DATA period
module idli_sqi_seq_m
  import idli_pkg::*;
(
  input  logic        i_seq_gck,
  input  logic        i_seq_rst,
  input  logic        i_seq_req_vld,
  input  logic        i_seq_req_rd,
  input  logic [15:0] i_seq_req_addr,
  input  logic [15:0] i_seq_req_data,
  output logic        o_seq_req_rdy,
  output logic [1:0]  o_seq_ctr,
  output logic        o_seq_ctr_last_cycle,
  output logic        o_seq_redirect,
  output logic        o_seq_rd,
  output logic [3:0]  o_seq_wr_data,
  output logic        o_seq_wr_data_vld,
  output logic [15:0] o_seq_addr
);

  logic [1:0] ctr;
  logic       ctr_last;

  idli_sqi_ctr_m u_ctr (
    .i_ctr_gck        (i_seq_gck),
    .i_ctr_rst        (i_seq_rst),
    .o_ctr            (ctr),
    .o_ctr_last_cycle (ctr_last)
  );

  // Request fields after configuration masking.
  logic        req_rd;
  logic [15:0] req_data;
  logic        unused_in;

`ifdef IDLI_SQI_SEQ_WR_EN
  assign req_rd    = i_seq_req_rd;
  assign req_data  = i_seq_req_data;
  assign unused_in = i_seq_req_addr[0];
`else
  assign req_rd    = 1'b1;
  assign req_data  = 16'h0000;
  assign unused_in = ^{i_seq_req_addr[0], i_seq_req_rd, i_seq_req_data};
`endif

  sqi_state_t  state_q, state_d;
  logic        pend_vld_q, pend_vld_d;
  logic        pend_rd_q, pend_rd_d;
  logic [15:0] pend_addr_q, pend_addr_d;
  logic [15:0] pend_data_q, pend_data_d;
  logic        act_rd_q, act_rd_d;
  logic [15:0] act_addr_q, act_addr_d;
  logic [15:0] act_data_q, act_data_d;
  logic [15:0] rd_addr_q, rd_addr_d;  // saved read-stream address
  logic        redirect;

  always_ff @(posedge i_seq_gck or posedge i_seq_rst) begin
    if (i_seq_rst) begin
      state_q     <= SqiInit;
      pend_vld_q  <= 1'b0;
      pend_rd_q   <= 1'b1;
      pend_addr_q <= 16'h0000;
      pend_data_q <= 16'h0000;
      act_rd_q    <= 1'b1;
      act_addr_q  <= 16'h0000;
      act_data_q  <= 16'h0000;
      rd_addr_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      pend_vld_q  <= pend_vld_d;
      pend_rd_q   <= pend_rd_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      act_rd_q    <= act_rd_d;
      act_addr_q  <= act_addr_d;
      act_data_q  <= act_data_d;
      rd_addr_q   <= rd_addr_d;
    end
  end

  // Registered-state only: a request accepted on this edge is seen one period later.
  assign redirect = (state_q == SqiData) && ctr_last && (pend_vld_q || !act_rd_q);

  always_comb begin
    state_d     = state_q;
    pend_vld_d  = pend_vld_q;
    pend_rd_d   = pend_rd_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    act_rd_d    = act_rd_q;
    act_addr_d  = act_addr_q;
    act_data_d  = act_data_q;
    rd_addr_d   = rd_addr_q;

    if (i_seq_req_vld && !pend_vld_q) begin
      pend_vld_d  = 1'b1;
      pend_rd_d   = req_rd;
      pend_addr_d = {i_seq_req_addr[15:1], 1'b0};
      pend_data_d = req_data;
    end

    if (ctr_last) begin
      unique case (state_q)
        SqiInit:  state_d = SqiAddr;
        SqiAddr:  state_d = SqiDummy;
        SqiDummy: state_d = SqiData;
        SqiData: begin
          if (redirect) begin
            state_d = SqiInit;
            if (pend_vld_q) begin
              pend_vld_d = 1'b0;
              act_rd_d   = pend_rd_q;
              act_addr_d = pend_addr_q;
              act_data_d = pend_data_q;
              if (pend_rd_q) begin
                rd_addr_d = pend_addr_q;
              end
            end else begin
              // Write finished with nothing queued: resume the interrupted read stream.
              act_rd_d   = 1'b1;
              act_addr_d = rd_addr_q;
            end
          end else begin
            // No redirect implies an ongoing read: advance to the next word.
            act_addr_d = act_addr_q + 16'd2;
            rd_addr_d  = act_addr_q + 16'd2;
          end
        end
        default: state_d = SqiInit;
      endcase
    end
  end

  always_comb begin
    o_seq_wr_data     = 4'h0;
    o_seq_wr_data_vld = 1'b0;
    unique case (state_q)
      SqiInit: begin
        o_seq_wr_data     = nibble_le(act_addr_q, ctr);
        o_seq_wr_data_vld = 1'b1;
      end
      SqiDummy: begin
        if (!act_rd_q) begin
          o_seq_wr_data     = nibble_le(act_data_q, ctr);
          o_seq_wr_data_vld = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign o_seq_req_rdy        = !pend_vld_q;
  assign o_seq_ctr            = ctr;
  assign o_seq_ctr_last_cycle = ctr_last;
  assign o_seq_redirect       = redirect;
  assign o_seq_rd             = act_rd_q;
  assign o_seq_addr           = act_addr_q;

endmodule

// File: tb/tb_idli_sqi_seq_m.sv
// Directed bench for idli_sqi_seq_m. Expected values are hand-derived per period.
// Write-path expectations follow IDLI_SQI_SEQ_WR_EN as the RTL does.
module tb_idli_sqi_seq_m;

  typedef enum int {PInit, PAddr, PDummy, PData} per_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rd = 1'b1;
  logic [15:0] req_addr = 16'h0000;
  logic [15:0] req_data = 16'h0000;
  logic        rdy;
  logic [1:0]  ctr;
  logic        last;
  logic        redirect;
  logic        rd;
  logic [3:0]  wr_data;
  logic        wr_vld;
  logic [15:0] addr;

  int          n_chk = 0;
  int          n_err = 0;
  string       phase = "reset";
  logic [15:0] cur;

  idli_sqi_seq_m dut (
    .i_seq_gck            (clk),
    .i_seq_rst            (rst),
    .i_seq_req_vld        (req_vld),
    .i_seq_req_rd         (req_rd),
    .i_seq_req_addr       (req_addr),
    .i_seq_req_data       (req_data),
    .o_seq_req_rdy        (rdy),
    .o_seq_ctr            (ctr),
    .o_seq_ctr_last_cycle (last),
    .o_seq_redirect       (redirect),
    .o_seq_rd             (rd),
    .o_seq_wr_data        (wr_data),
    .o_seq_wr_data_vld    (wr_vld),
    .o_seq_addr           (addr)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got 0x%0h expected 0x%0h", phase, tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset();
    check_eq("rst_ctr", 32'(ctr), 32'd0);
    check_eq("rst_last", 32'(last), 32'd0);
    check_eq("rst_rdy", 32'(rdy), 32'd1);
    check_eq("rst_rd", 32'(rd), 32'd1);
    check_eq("rst_redirect", 32'(redirect), 32'd0);
    check_eq("rst_vld", 32'(wr_vld), 32'd1);
    check_eq("rst_nib", 32'(wr_data), 32'd0);
    check_eq("rst_addr", 32'(addr), 32'd0);
  endtask

  // Runs one 4-cycle period starting at ctr==0, optionally driving a request for one cycle
  // at sample index inj, then checks the period against the expectations for its kind.
  task automatic period(input per_t kind, input logic [15:0] exp_val, input logic exp_rd,
                        input logic exp_redir, input int inj = -1, input logic r_rd = 1'b1,
                        input logic [15:0] r_addr = 16'h0, input logic [15:0] r_data = 16'h0,
                        input logic exp_rdy = 1'b1);
    logic [15:0] word;
    logic [3:0]  vlds;
    logic [3:0]  redirs;
    logic [15:0] a0;
    logic        rd0;
    logic        rdy_inj;
    word    = '0;
    vlds    = '0;
    redirs  = '0;
    a0      = '0;
    rd0     = 1'b0;
    rdy_inj = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check_eq("ctr", 32'(ctr), 32'(i));
      check_eq("last", 32'(last), 32'(i == 3));
      word[4*i +: 4] = wr_data;
      vlds[i]        = wr_vld;
      redirs[i]      = redirect;
      if (i == 0) begin
        a0  = addr;
        rd0 = rd;
      end
      if (i == inj) begin
        rdy_inj  = rdy;
        req_vld  = 1'b1;
        req_rd   = r_rd;
        req_addr = r_addr;
        req_data = r_data;
      end
      step();
      req_vld = 1'b0;
    end
    check_eq("rd", 32'(rd0), 32'(exp_rd));
    if (inj >= 0) check_eq("req_rdy", 32'(rdy_inj), 32'(exp_rdy));
    case (kind)
      PInit: begin
        check_eq("init_vld", 32'(vlds), 32'hF);
        check_eq("init_nibs", 32'(word), 32'(exp_val));
        check_eq("init_redir", 32'(redirs), 32'h0);
      end
      PAddr: begin
        check_eq("addr_vld", 32'(vlds), 32'h0);
        check_eq("addr_redir", 32'(redirs), 32'h0);
      end
      PDummy: begin
        check_eq("dummy_vld", 32'(vlds), exp_rd ? 32'h0 : 32'hF);
        if (!exp_rd) check_eq("dummy_nibs", 32'(word), 32'(exp_val));
        check_eq("dummy_redir", 32'(redirs), 32'h0);
      end
      default: begin
        check_eq("data_vld", 32'(vlds), 32'h0);
        check_eq("data_addr", 32'(a0), 32'(exp_val));
        check_eq("data_redir", 32'(redirs), exp_redir ? 32'h8 : 32'h0);
      end
    endcase
  endtask

  task automatic prologue(input logic [15:0] a, input logic rdf, input logic [15:0] d);
    period(PInit, a, rdf, 1'b0);
    period(PAddr, 16'h0, rdf, 1'b0);
    period(PDummy, d, rdf, 1'b0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    phase = "boot";
    prologue(16'h0000, 1'b1, 16'h0);
    period(PData, 16'h0000, 1'b1, 1'b0);
    period(PData, 16'h0002, 1'b1, 1'b0);
    period(PData, 16'h0004, 1'b1, 1'b0);

    phase = "rd_redirect";
    period(PData, 16'h0006, 1'b1, 1'b1, 1, 1'b1, 16'h1234, 16'h0, 1'b1);
    prologue(16'h1234, 1'b1, 16'h0);
    period(PData, 16'h1234, 1'b1, 1'b0);
    period(PData, 16'h1236, 1'b1, 1'b1, 2, 1'b1, 16'h0040, 16'h0, 1'b1);

    phase = "write";
    prologue(16'h0040, 1'b1, 16'h0);
    period(PData, 16'h0040, 1'b1, 1'b1, 0, 1'b0, 16'h0100, 16'hBEEF, 1'b1);
`ifdef IDLI_SQI_SEQ_WR_EN
    prologue(16'h0100, 1'b0, 16'hBEEF);
    period(PData, 16'h0100, 1'b0, 1'b1);
    phase = "resume";
    prologue(16'h0040, 1'b1, 16'h0);
    period(PData, 16'h0040, 1'b1, 1'b0);
    period(PData, 16'h0042, 1'b1, 1'b0);
    cur = 16'h0044;
`else
    prologue(16'h0100, 1'b1, 16'h0);
    period(PData, 16'h0100, 1'b1, 1'b0);
    period(PData, 16'h0102, 1'b1, 1'b0);
    cur = 16'h0104;
`endif

    // Request lands on the last-cycle edge: redirect waits a full period, slot stays busy.
    phase = "late_req";
    period(PData, cur, 1'b1, 1'b0, 3, 1'b1, 16'h2000, 16'h0, 1'b1);
    period(PData, cur + 16'd2, 1'b1, 1'b1, 1, 1'b1, 16'h3000, 16'h0, 1'b0);
    prologue(16'h2000, 1'b1, 16'h0);
    period(PData, 16'h2000, 1'b1, 1'b0);
    period(PData, 16'h2002, 1'b1, 1'b1, 0, 1'b1, 16'hFFFD, 16'h0, 1'b1);

    phase = "wrap";
    prologue(16'hFFFC, 1'b1, 16'h0);
    period(PData, 16'hFFFC, 1'b1, 1'b0);
    period(PData, 16'hFFFE, 1'b1, 1'b0);
    period(PData, 16'h0000, 1'b1, 1'b1, 1, 1'b0, 16'h0200, 16'h1357, 1'b1);

    phase = "reset_mid";
`ifdef IDLI_SQI_SEQ_WR_EN
    period(PInit, 16'h0200, 1'b0, 1'b0);
    period(PAddr, 16'h0, 1'b0, 1'b0);
    check_eq("dummy_nib0", 32'(wr_data), 32'h7);
    check_eq("dummy_vld0", 32'(wr_vld), 32'h1);
    step();
    check_eq("dummy_nib1", 32'(wr_data), 32'h5);
    check_eq("dummy_vld1", 32'(wr_vld), 32'h1);
`else
    period(PInit, 16'h0200, 1'b1, 1'b0);
    period(PAddr, 16'h0, 1'b1, 1'b0);
    check_eq("dummy_vld0", 32'(wr_vld), 32'h0);
    step();
    check_eq("dummy_vld1", 32'(wr_vld), 32'h0);
`endif
    #2;
    rst = 1'b1;
    #1;
    check_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset();

    phase = "reboot";
    prologue(16'h0000, 1'b1, 16'h0);
    period(PData, 16'h0000, 1'b1, 1'b0);
    period(PData, 16'h0002, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
